// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch (IF) and the
// load/store stage (MEM), with fixed read latency and a fetch starvation guard.
module unified_mem_arbiter #(
  parameter int ADDR_LEN     = 32,
  parameter int DATA_LEN     = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_addr,
  output logic [DATA_LEN-1:0] if_rdata,
  output logic                if_ready,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_LEN-1:0] mem_addr,
  input  logic [DATA_LEN-1:0] mem_wdata,
  output logic [DATA_LEN-1:0] mem_rdata,
  output logic                mem_ready,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_LEN-1:0] ram_addr,
  output logic [DATA_LEN-1:0] ram_wdata,
  input  logic [DATA_LEN-1:0] ram_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT        = 4'(MEM_LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t              state_reg, state_next;
  logic                owner_if_reg, owner_if_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [3:0]          starve_reg, starve_next;
  logic                ram_en_reg, ram_en_next;
  logic                ram_we_reg, ram_we_next;
  logic [ADDR_LEN-1:0] ram_addr_reg, ram_addr_next;
  logic [DATA_LEN-1:0] ram_wdata_reg, ram_wdata_next;
  logic [DATA_LEN-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_LEN-1:0] mem_rdata_reg, mem_rdata_next;
  logic                if_ready_reg, if_ready_next;
  logic                mem_ready_reg, mem_ready_next;
  logic                grant_if;

  // IF wins only when MEM is idle or MEM has used up its starvation allowance.
  assign grant_if = if_req & (~mem_req | (starve_reg == STARVE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      owner_if_reg  <= 1'b0;
      cnt_reg       <= '0;
      starve_reg    <= '0;
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
      if_ready_reg  <= 1'b0;
      mem_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_if_reg  <= owner_if_next;
      cnt_reg       <= cnt_next;
      starve_reg    <= starve_next;
      ram_en_reg    <= ram_en_next;
      ram_we_reg    <= ram_we_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      mem_rdata_reg <= mem_rdata_next;
      if_ready_reg  <= if_ready_next;
      mem_ready_reg <= mem_ready_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_if_next  = owner_if_reg;
    cnt_next       = cnt_reg;
    starve_next    = starve_reg;
    ram_en_next    = 1'b0;
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    mem_rdata_next = mem_rdata_reg;
    if_ready_next  = 1'b0;
    mem_ready_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // The RAM strobe and latched request are registered on the grant edge,
        // so they appear exactly in the ISSUE cycle.
        if (if_req || mem_req) begin
          state_next  = ISSUE;
          ram_en_next = 1'b1;
          if (grant_if) begin
            owner_if_next  = 1'b1;
            ram_addr_next  = if_addr;
            ram_we_next    = 1'b0;
            ram_wdata_next = '0;
            starve_next    = '0;
          end else begin
            owner_if_next  = 1'b0;
            ram_addr_next  = mem_addr;
            ram_we_next    = mem_we;
            ram_wdata_next = mem_wdata;
            if (if_req && (starve_reg != STARVE_MAX)) begin
              starve_next = starve_reg + 4'd1;
            end
          end
        end
      end
      ISSUE: begin
        if (ram_we_reg) begin
          state_next     = RESP;
          mem_ready_next = 1'b1;
        end else begin
          state_next = WAIT;
          cnt_next   = LAT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
          if (owner_if_reg) begin
            if_rdata_next = ram_rdata;
            if_ready_next = 1'b1;
          end else begin
            mem_rdata_next = ram_rdata;
            mem_ready_next = 1'b1;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign if_rdata  = if_rdata_reg;
  assign if_ready  = if_ready_reg;
  assign mem_rdata = mem_rdata_reg;
  assign mem_ready = mem_ready_reg;
  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign stall_if  = if_req & ~if_ready_reg;
  assign stall_mem = mem_req & ~mem_ready_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified RAM between the CPU IF stage (instruction fetch) and the MEM stage (load/store).
- Serialises accesses, handles a fixed multi-cycle RAM latency, and returns per-requester ready pulses.
- Produces stall signals that the pipeline hazard logic ORs into its PC-hold, IF/ID-hold and EX/MEM-hold controls.
- MEM stage has priority by default. A starvation counter guarantees fetch progress.

Parameters:
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, data width.
- MEM_LATENCY, 2, cycles from the ram_en cycle to valid ram_rdata. Legal range 1..15; the counter is 4 bits.
- STARVE_LIMIT, 4, number of consecutive MEM grants with if_req pending, after which IF wins the next arbitration. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  ADDR_LEN  fetch address.
- if_rdata  out  DATA_LEN  fetched word; valid while if_ready is high.
- if_ready  out  1  one-cycle completion pulse.
- mem_req  in  1  data request; held high until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_LEN  data address.
- mem_wdata  in  DATA_LEN  store data.
- mem_rdata  out  DATA_LEN  load data; valid while mem_ready is high.
- mem_ready  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM access strobe, one cycle per access.
- ram_we  out  1  RAM write enable, qualified by ram_en.
- ram_addr  out  ADDR_LEN  RAM address.
- ram_wdata  out  DATA_LEN  RAM write data.
- ram_rdata  in  DATA_LEN  RAM read data; valid MEM_LATENCY cycles after the ram_en cycle.
- stall_if  out  1  if_req & ~if_ready (combinational).
- stall_mem  out  1  mem_req & ~mem_ready (combinational).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; owner=MEM; cnt=0; starve=0.
  - All registered outputs (rdata, ready, ram_en, ram_we, ram_addr, ram_wdata) are 0.
  - A reset mid-access aborts it: no ready pulse is issued and ram_en drops immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate among the pending requests.
  - Only one requester pending: that requester is granted.
  - Both pending: MEM is granted, unless starve==STARVE_LIMIT, in which case IF is granted.
  - On a grant, latch owner, addr, we (forced 0 for IF) and wdata, then go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE: ram_en=1; ram_we=latched we; ram_addr and ram_wdata come from the latched values.
  - Store: go to RESP.
  - Load or fetch: cnt<=MEM_LATENCY and go to WAIT.
- WAIT: cnt decrements each cycle.
  - When cnt==1, capture ram_rdata into the owner's rdata register and go to RESP.
- RESP: the owner's ready is 1 for exactly this cycle, then go to IDLE.
  - No back-to-back grant from RESP; a new arbitration always passes through IDLE.
- Latency, with a request first seen in IDLE at cycle T:
  - Load/fetch: ram_en at T+1, ready at T+2+MEM_LATENCY.
  - Store: ready at T+2.
- Starvation counter:
  - starve increments, saturating at STARVE_LIMIT, on each MEM grant made while if_req=1.
  - starve clears on every IF grant.
- Data hold and latching rules:
  - rdata registers hold their last value until overwritten.
  - A store never modifies mem_rdata.
  - Request inputs are sampled only at grant. Address or data changes after the grant are ignored for that access.
- Request dropped before ready (e.g. an IF flush): the access still completes and the ready pulse is still issued; the requester ignores it.
- ram_en is never high in two consecutive cycles, and never high outside ISSUE.

Test Plan:
1. Fetch, MEM_LATENCY=2: if_req=1, if_addr=0x40 at cycle 0; ram_rdata=0x20080005 at cycle 3 -> ram_en=1, ram_addr=0x40, ram_we=0 at cycle 1; if_ready=1 and if_rdata=0x20080005 at cycle 4; stall_if=1 in cycles 0-3.
2. Simultaneous IF and MEM load at cycle 0 -> MEM issues at cycle 1, mem_ready at cycle 4; IF issues at cycle 6, if_ready at cycle 9; busy is low only at cycle 5.
3. Store: mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF -> at cycle 1 ram_en=1, ram_we=1, ram_wdata=0xDEADBEEF; mem_ready at cycle 2; mem_rdata unchanged.
4. Starvation, STARVE_LIMIT=4: mem_req is re-asserted every IDLE and if_req is held high -> 4 MEM grants, then IF is granted on the 5th arbitration; starve reads 0 afterwards.
5. Reset mid-access: rst=0 in the WAIT of a load -> ram_en, mem_ready and busy go to 0 immediately and no ready pulse follows; after rst=1, a new fetch completes with the normal T+4 latency.
6. MEM_LATENCY=1 build: fetch at cycle 0 -> ram_en at cycle 1, ram_rdata captured at cycle 2, if_ready at cycle 3.
